// File: rtl/reward_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : eer_pkg                                                         |
// | Purpose  : Shared widths, packet types, FSM states and the reply-rule      |
// |            decoder for the EER-RL-HM reward/reply packet builder.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package eer_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int NT_INDEX_W = 6;

    localparam logic [15:0] BROADCAST_ID = 16'hFFFF;
    localparam logic [15:0] HOPS_INF     = 16'hFFFF;

    typedef enum logic [2:0] {
        PKT_HB   = 3'd0,
        PKT_CHE  = 3'd1,
        PKT_INV  = 3'd2,
        PKT_MR   = 3'd3,
        PKT_DATA = 3'd4,
        PKT_ACK  = 3'd5
    } pkt_type_t;

    // FSM encoding, kept as plain constants so older sinks can decode it
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_SCAN   = 3'd2;
    localparam logic [2:0] ST_BUILD  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [1:0] {
        DEST_BCAST = 2'd0,  // broadcast
        DEST_CH    = 2'd1,  // our chosen cluster head
        DEST_SRC   = 2'd2,  // sender of the incoming packet
        DEST_HOP   = 2'd3   // next hop from table scan, falling back to CH
    } dest_sel_t;

    typedef struct packed {
        logic      build;
        logic      scan;
        pkt_type_t pktType;
        dest_sel_t destSel;
    } action_t;

    // Maps incoming packet type and own state to the reply to be built.
    // A pending data packet is only forwarded when we are not the target;
    // an ACK to the sender always wins over our own data.
    function automatic action_t decodeAction(input logic [2:0] fType,
                                             input logic       role,
                                             input logic       iAmDest,
                                             input logic       iHaveData);
        action_t a;
        a = '{build: 1'b0, scan: 1'b0, pktType: PKT_HB, destSel: DEST_BCAST};
        case (fType)
            PKT_HB: begin
                a.build = 1'b1;
                if (iHaveData && !iAmDest) begin
                    a.scan    = 1'b1;
                    a.pktType = PKT_DATA;
                    a.destSel = DEST_HOP;
                end
            end
            PKT_CHE: begin
                a.build   = 1'b1;
                a.pktType = role ? PKT_INV : PKT_CHE;
            end
            PKT_INV: begin
                if (!role) begin
                    a.build   = 1'b1;
                    a.pktType = PKT_MR;
                    a.destSel = DEST_CH;
                end
            end
            PKT_MR: begin
                if (iAmDest) begin
                    a.build   = 1'b1;
                    a.pktType = PKT_ACK;
                    a.destSel = DEST_SRC;
                end
            end
            PKT_DATA: begin
                if (iAmDest) begin
                    a.build   = 1'b1;
                    a.pktType = PKT_ACK;
                    a.destSel = DEST_SRC;
                end else if (iHaveData) begin
                    a.build   = 1'b1;
                    a.scan    = 1'b1;
                    a.pktType = PKT_DATA;
                    a.destSel = DEST_HOP;
                end
            end
            default: ;
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reward_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reward_unit_if                                                  |
// | Purpose  : Node state, filtered packet fields, neighbor-table read port    |
// |            and outgoing reward-packet fields of the reward unit.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface reward_unit_if #(
    parameter int WORD_WIDTH = eer_pkg::WORD_WIDTH,
    parameter int NT_INDEX_W = eer_pkg::NT_INDEX_W
);
    // control and own node state
    logic                  en;
    logic [2:0]            fPacketType;
    logic [WORD_WIDTH-1:0] myEnergy;
    logic                  iHaveData;
    logic                  iAmDestination;
    logic [WORD_WIDTH-1:0] myNodeID;
    logic [WORD_WIDTH-1:0] hopsFromSink;
    logic [WORD_WIDTH-1:0] myQValue;
    logic                  role;
    logic                  low_E;
    // filtered incoming packet
    logic [WORD_WIDTH-1:0] fSourceID;
    logic [WORD_WIDTH-1:0] fSourceHops;
    logic [WORD_WIDTH-1:0] fQValue;
    logic [WORD_WIDTH-1:0] fEnergyLeft;
    logic [WORD_WIDTH-1:0] fHopsFromCH;
    logic [WORD_WIDTH-1:0] fChosenCH;
    // KCH / QTUFMB results
    logic [WORD_WIDTH-1:0] chosenCH;
    logic [WORD_WIDTH-1:0] hopsFromCH;
    logic [WORD_WIDTH-1:0] chosenHop;
    // neighbor table
    logic [4:0]            neighborCount;
    logic [WORD_WIDTH-1:0] mNodeID;
    logic [WORD_WIDTH-1:0] mNodeHops;
    logic [WORD_WIDTH-1:0] mNodeQValue;
    logic [WORD_WIDTH-1:0] mNodeEnergy;
    logic [WORD_WIDTH-1:0] mNodeCHHops;
    logic [NT_INDEX_W-1:0] nTableIndex_reward;
    // outgoing reward packet
    logic [WORD_WIDTH-1:0] rSourceID;
    logic [WORD_WIDTH-1:0] rEnergyLeft;
    logic [WORD_WIDTH-1:0] rQValue;
    logic [WORD_WIDTH-1:0] rSourceHops;
    logic [WORD_WIDTH-1:0] rDestinationID;
    logic [WORD_WIDTH-1:0] rChosenCH;
    logic [WORD_WIDTH-1:0] rHopsFromCH;
    logic [2:0]            rPacketType;
    logic                  reward_done;

    modport master (
        output en, fPacketType, myEnergy, iHaveData, iAmDestination, myNodeID,
               hopsFromSink, myQValue, role, low_E, fSourceID, fSourceHops,
               fQValue, fEnergyLeft, fHopsFromCH, fChosenCH, chosenCH,
               hopsFromCH, chosenHop, neighborCount, mNodeID, mNodeHops,
               mNodeQValue, mNodeEnergy, mNodeCHHops,
        input  nTableIndex_reward, rSourceID, rEnergyLeft, rQValue, rSourceHops,
               rDestinationID, rChosenCH, rHopsFromCH, rPacketType, reward_done
    );

    modport slave (
        input  en, fPacketType, myEnergy, iHaveData, iAmDestination, myNodeID,
               hopsFromSink, myQValue, role, low_E, fSourceID, fSourceHops,
               fQValue, fEnergyLeft, fHopsFromCH, fChosenCH, chosenCH,
               hopsFromCH, chosenHop, neighborCount, mNodeID, mNodeHops,
               mNodeQValue, mNodeEnergy, mNodeCHHops,
        output nTableIndex_reward, rSourceID, rEnergyLeft, rQValue, rSourceHops,
               rDestinationID, rChosenCH, rHopsFromCH, rPacketType, reward_done
    );
endinterface
`default_nettype wire

// File: rtl/reward_unit_nt_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reward_nt_scan                                                  |
// | Purpose  : Walks the neighbor table one entry per clock looking for the    |
// |            chosen next hop; reports a hit and the last-entry condition.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module reward_nt_scan #(
    parameter int WORD_WIDTH = 16,
    parameter int NT_INDEX_W = 6
) (
    input  wire logic                  clk,
    input  wire logic                  nrst,
    input  wire logic                  i_active,
    input  wire logic [WORD_WIDTH-1:0] i_chosenHop,
    input  wire logic [4:0]            i_neighborCount,
    input  wire logic [WORD_WIDTH-1:0] i_entryID,
    output logic      [NT_INDEX_W-1:0] o_index,
    output logic                       o_found,
    output logic                       o_last
);
    logic [NT_INDEX_W-1:0] r_index;
    logic [NT_INDEX_W-1:0] w_lastIdx;

    // Entry data is a combinational read, so the match is judged in the same cycle
    assign w_lastIdx = NT_INDEX_W'(i_neighborCount) - NT_INDEX_W'(1);
    assign o_found   = i_active && (i_entryID == i_chosenHop);
    assign o_last    = (r_index == w_lastIdx);
    assign o_index   = r_index;

    // Advance while scanning; park at 0 once the scan ends or is idle
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_index <= '0;
        end else if (i_active && !o_found && !o_last) begin
            r_index <= r_index + NT_INDEX_W'(1);
        end else begin
            r_index <= '0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/reward_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reward_unit                                                     |
// | Purpose  : Builds the reply/reward packet fields from the filtered         |
// |            incoming packet and own node state, with optional next-hop      |
// |            lookup in the neighbor table.                                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module reward_unit
    import eer_pkg::*;
#(
    parameter int WORD_WIDTH = eer_pkg::WORD_WIDTH,
    parameter int NT_INDEX_W = eer_pkg::NT_INDEX_W
) (
    input wire logic    clk,
    input wire logic    nrst,
    reward_unit_if.slave bus
);
    logic [2:0]            r_state;
    // request snapshot taken in DECODE
    logic [2:0]            r_fType;
    logic                  r_role, r_amDest, r_haveData, r_lowE, r_found;
    logic [WORD_WIDTH-1:0] r_myNodeID, r_myEnergy, r_hopsFromSink, r_myQValue;
    logic [WORD_WIDTH-1:0] r_fSourceID, r_chosenCH, r_hopsFromCH, r_chosenHop;
    logic [4:0]            r_neighborCount;
    // outgoing packet
    logic [WORD_WIDTH-1:0] r_rSourceID, r_rEnergyLeft, r_rQValue, r_rSourceHops;
    logic [WORD_WIDTH-1:0] r_rDestinationID, r_rChosenCH, r_rHopsFromCH;
    logic [2:0]            r_rPacketType;
    logic                  r_done;

    action_t               w_liveAct, w_act;
    logic [WORD_WIDTH-1:0] w_dest;
    logic [NT_INDEX_W-1:0] w_index;
    logic                  w_hit, w_last;

    // Live decode only chooses between SCAN and BUILD; the build uses the snapshot
    assign w_liveAct = decodeAction(bus.fPacketType, bus.role, bus.iAmDestination, bus.iHaveData);
    assign w_act     = decodeAction(r_fType, r_role, r_amDest, r_haveData);

    reward_nt_scan #(
        .WORD_WIDTH (WORD_WIDTH),
        .NT_INDEX_W (NT_INDEX_W)
    ) u_scan (
        .clk             (clk),
        .nrst            (nrst),
        .i_active        (r_state == ST_SCAN),
        .i_chosenHop     (r_chosenHop),
        .i_neighborCount (r_neighborCount),
        .i_entryID       (bus.mNodeID),
        .o_index         (w_index),
        .o_found         (w_hit),
        .o_last          (w_last)
    );

    // Destination for the packet being built; a missed lookup falls back to the CH
    always_comb begin
        w_dest = BROADCAST_ID;
        case (w_act.destSel)
            DEST_BCAST: w_dest = BROADCAST_ID;
            DEST_CH:    w_dest = r_chosenCH;
            DEST_SRC:   w_dest = r_fSourceID;
            DEST_HOP:   w_dest = r_found ? r_chosenHop : r_chosenCH;
            default:    w_dest = BROADCAST_ID;
        endcase
    end

    // Sequencing, request snapshot and lookup result
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_state         <= ST_IDLE;
            r_fType         <= '0;
            r_role          <= 1'b0;
            r_amDest        <= 1'b0;
            r_haveData      <= 1'b0;
            r_lowE          <= 1'b0;
            r_found         <= 1'b0;
            r_myNodeID      <= '0;
            r_myEnergy      <= '0;
            r_hopsFromSink  <= '0;
            r_myQValue      <= '0;
            r_fSourceID     <= '0;
            r_chosenCH      <= '0;
            r_hopsFromCH    <= '0;
            r_chosenHop     <= '0;
            r_neighborCount <= '0;
            r_done          <= 1'b0;
        end else begin
            r_done <= (r_state == ST_BUILD);
            case (r_state)
                ST_IDLE: begin
                    if (bus.en) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_fType         <= bus.fPacketType;
                    r_role          <= bus.role;
                    r_amDest        <= bus.iAmDestination;
                    r_haveData      <= bus.iHaveData;
                    r_lowE          <= bus.low_E;
                    r_myNodeID      <= bus.myNodeID;
                    r_myEnergy      <= bus.myEnergy;
                    r_hopsFromSink  <= bus.hopsFromSink;
                    r_myQValue      <= bus.myQValue;
                    r_fSourceID     <= bus.fSourceID;
                    r_chosenCH      <= bus.chosenCH;
                    r_hopsFromCH    <= bus.hopsFromCH;
                    r_chosenHop     <= bus.chosenHop;
                    r_neighborCount <= bus.neighborCount;
                    r_found         <= 1'b0;
                    r_state <= (w_liveAct.scan && (bus.neighborCount != 5'd0)) ? ST_SCAN : ST_BUILD;
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        r_found <= 1'b1;
                        r_state <= ST_BUILD;
                    end else if (w_last) begin
                        r_state <= ST_BUILD;
                    end
                end
                ST_BUILD: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Packet fields change only when a reply is actually built; otherwise they hold
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_rSourceID      <= '0;
            r_rEnergyLeft    <= '0;
            r_rQValue        <= '0;
            r_rSourceHops    <= '0;
            r_rDestinationID <= BROADCAST_ID;
            r_rChosenCH      <= '0;
            r_rHopsFromCH    <= HOPS_INF;
            r_rPacketType    <= '0;
        end else if ((r_state == ST_BUILD) && w_act.build) begin
            r_rSourceID      <= r_myNodeID;
            r_rEnergyLeft    <= r_myEnergy;
            // advertising Q=0 steers neighbors away from a depleted node
            r_rQValue        <= r_lowE ? '0 : r_myQValue;
            r_rSourceHops    <= r_hopsFromSink;
            r_rDestinationID <= w_dest;
            r_rChosenCH      <= r_role ? r_myNodeID : r_chosenCH;
            r_rHopsFromCH    <= r_role ? '0 : r_hopsFromCH;
            r_rPacketType    <= w_act.pktType;
        end
    end

    assign bus.rSourceID          = r_rSourceID;
    assign bus.rEnergyLeft        = r_rEnergyLeft;
    assign bus.rQValue            = r_rQValue;
    assign bus.rSourceHops        = r_rSourceHops;
    assign bus.rDestinationID     = r_rDestinationID;
    assign bus.rChosenCH          = r_rChosenCH;
    assign bus.rHopsFromCH        = r_rHopsFromCH;
    assign bus.rPacketType        = r_rPacketType;
    assign bus.nTableIndex_reward = w_index;
    assign bus.reward_done        = r_done;
endmodule
`default_nettype wire

// File: tb/tb_reward_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reward_unit                                                  |
// | Purpose  : Self-checking bench for reward_unit: directed vector table,     |
// |            mid-scan reset sequence and randomized traffic vs a model.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_reward_unit;

    typedef struct {
        logic [2:0]  ftype;
        logic        role, amDest, haveData, lowE;
        logic [15:0] myID, energy, hops, myQ, fSrc, cch, hcch, hop;
        logic [4:0]  count;
    } stim_t;

    typedef struct {
        logic [2:0]  ptype;
        logic [15:0] src, energy, q, hops, dest, cch, hcch;
        int          lat;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk;
    logic        nrst;
    logic [15:0] nt [0:63];
    int          nVec;
    int          nBad;

    reward_unit_if ifc ();

    reward_unit u_dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // neighbor table model: combinational read at the DUT's index
    assign ifc.mNodeID     = nt[ifc.nTableIndex_reward];
    assign ifc.mNodeHops   = 16'h0002;
    assign ifc.mNodeQValue = 16'h0040;
    assign ifc.mNodeEnergy = 16'h1000;
    assign ifc.mNodeCHHops = 16'h0001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nVec++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reply rules stated directly: which packet, to whom, and how many table
    // entries the next-hop search has to look at.
    function automatic exp_t model(input stim_t s, input exp_t prev);
        exp_t        e;
        bit          send, fwd, hit;
        logic [2:0]  t;
        logic [15:0] d;
        int          k;
        e = prev; send = 0; fwd = 0; hit = 0; t = 3'd0; d = 16'hFFFF; k = 0;
        case (s.ftype)
            3'd0: if (s.haveData && !s.amDest) fwd = 1; else begin send = 1; t = 3'd0; end
            3'd1: begin send = 1; t = s.role ? 3'd2 : 3'd1; end
            3'd2: if (!s.role) begin send = 1; t = 3'd3; d = s.cch; end
            3'd3: if (s.amDest) begin send = 1; t = 3'd5; d = s.fSrc; end
            3'd4: if (s.amDest) begin send = 1; t = 3'd5; d = s.fSrc; end
                  else if (s.haveData) fwd = 1;
            default: ;
        endcase
        if (fwd) begin
            send = 1; t = 3'd4; d = s.cch; k = int'(s.count);
            for (int i = 0; i < int'(s.count); i++) begin
                if (!hit && nt[i] == s.hop) begin
                    hit = 1; d = s.hop; k = i + 1;
                end
            end
        end
        if (send) begin
            e.ptype  = t;
            e.src    = s.myID;
            e.energy = s.energy;
            e.q      = s.lowE ? 16'h0000 : s.myQ;
            e.hops   = s.hops;
            e.dest   = d;
            e.cch    = s.role ? s.myID : s.cch;
            e.hcch   = s.role ? 16'h0000 : s.hcch;
        end
        e.lat = 3 + k;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        ifc.fPacketType    = s.ftype;
        ifc.role           = s.role;
        ifc.iAmDestination = s.amDest;
        ifc.iHaveData      = s.haveData;
        ifc.low_E          = s.lowE;
        ifc.myNodeID       = s.myID;
        ifc.myEnergy       = s.energy;
        ifc.hopsFromSink   = s.hops;
        ifc.myQValue       = s.myQ;
        ifc.fSourceID      = s.fSrc;
        ifc.chosenCH       = s.cch;
        ifc.hopsFromCH     = s.hcch;
        ifc.chosenHop      = s.hop;
        ifc.neighborCount  = s.count;
    endtask

    task automatic chkOut(input string tag, input exp_t e);
        chk({tag, "_type"},   {29'd0, ifc.rPacketType}, {29'd0, e.ptype});
        chk({tag, "_src"},    {16'd0, ifc.rSourceID},      {16'd0, e.src});
        chk({tag, "_energy"}, {16'd0, ifc.rEnergyLeft},    {16'd0, e.energy});
        chk({tag, "_q"},      {16'd0, ifc.rQValue},        {16'd0, e.q});
        chk({tag, "_hops"},   {16'd0, ifc.rSourceHops},    {16'd0, e.hops});
        chk({tag, "_dest"},   {16'd0, ifc.rDestinationID}, {16'd0, e.dest});
        chk({tag, "_ch"},     {16'd0, ifc.rChosenCH},      {16'd0, e.cch});
        chk({tag, "_chhops"}, {16'd0, ifc.rHopsFromCH},    {16'd0, e.hcch});
    endtask

    // One request: pulse en, wait for reward_done (bounded), check latency,
    // fields, index park and the single-cycle pulse width. Called at a negedge.
    task automatic run(input string tag, input stim_t s, input exp_t e);
        int lat;
        drive(s);
        ifc.en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.en = 1'b0;
        lat = 1;
        while (ifc.reward_done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, e.lat);
        if (ifc.reward_done === 1'b1) begin
            chkOut(tag, e);
            chk({tag, "_index"}, {26'd0, ifc.nTableIndex_reward}, 32'd0);
            @(negedge clk);
            chk({tag, "_pulse"}, {31'd0, ifc.reward_done}, 32'd0);
        end
    endtask

    function automatic exp_t mkExp(input logic [2:0] t, input logic [15:0] q, input logic [15:0] dest,
                                   input logic [15:0] cch, input logic [15:0] hcch, input int lat);
        exp_t e;
        e = '{ptype: t, src: 16'h000C, energy: 16'h8000, q: q, hops: 16'h0001,
              dest: dest, cch: cch, hcch: hcch, lat: lat};
        return e;
    endfunction

    initial begin
        vec_t  tbl [10];
        stim_t base, s;
        exp_t  resetExp, prev, e;
        int    doneSeen;

        nVec = 0;
        nBad = 0;
        for (int i = 0; i < 64; i++) nt[i] = 16'h0000;
        nt[0] = 16'h0003; nt[1] = 16'h0005; nt[2] = 16'h0009;

        base = '{ftype: 3'd0, role: 1'b0, amDest: 1'b0, haveData: 1'b0, lowE: 1'b0,
                 myID: 16'h000C, energy: 16'h8000, hops: 16'h0001, myQ: 16'h0123,
                 fSrc: 16'h0007, cch: 16'h0002, hcch: 16'h0003, hop: 16'h0005, count: 5'd3};
        resetExp = '{ptype: 3'd0, src: 16'h0, energy: 16'h0, q: 16'h0, hops: 16'h0,
                     dest: 16'hFFFF, cch: 16'h0, hcch: 16'hFFFF, lat: 3};

        ifc.en = 1'b0;
        ifc.fSourceHops = 16'h0004; ifc.fQValue = 16'h0033; ifc.fEnergyLeft = 16'h0500;
        ifc.fHopsFromCH = 16'h0002; ifc.fChosenCH = 16'h0008;
        drive(base);

        // reset state
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        chkOut("reset", resetExp);
        chk("reset_index", {26'd0, ifc.nTableIndex_reward}, 32'd0);
        chk("reset_done", {31'd0, ifc.reward_done}, 32'd0);
        nrst = 1'b0;
        @(negedge clk);

        // directed table
        for (int i = 0; i < 10; i++) tbl[i].s = base;
        tbl[0].e = mkExp(3'd0, 16'h0123, 16'hFFFF, 16'h0002, 16'h0003, 3);
        tbl[1].s.ftype = 3'd1; tbl[1].s.role = 1'b1;
        tbl[1].e = mkExp(3'd2, 16'h0123, 16'hFFFF, 16'h000C, 16'h0000, 3);
        tbl[2].s.ftype = 3'd4; tbl[2].s.amDest = 1'b1; tbl[2].s.haveData = 1'b1;
        tbl[2].e = mkExp(3'd5, 16'h0123, 16'h0007, 16'h0002, 16'h0003, 3);
        tbl[3].s.ftype = 3'd4; tbl[3].s.haveData = 1'b1;
        tbl[3].e = mkExp(3'd4, 16'h0123, 16'h0005, 16'h0002, 16'h0003, 5);
        tbl[4].s.ftype = 3'd4; tbl[4].s.haveData = 1'b1; tbl[4].s.hop = 16'h0011; tbl[4].s.lowE = 1'b1;
        tbl[4].e = mkExp(3'd4, 16'h0000, 16'h0002, 16'h0002, 16'h0003, 6);
        tbl[5].s.ftype = 3'd3; tbl[5].s.energy = 16'h1111;
        tbl[5].e = tbl[4].e; tbl[5].e.lat = 3;
        tbl[6].s.ftype = 3'd2;
        tbl[6].e = mkExp(3'd3, 16'h0123, 16'h0002, 16'h0002, 16'h0003, 3);
        tbl[7].s.ftype = 3'd0; tbl[7].s.haveData = 1'b1; tbl[7].s.count = 5'd0;
        tbl[7].e = mkExp(3'd4, 16'h0123, 16'h0002, 16'h0002, 16'h0003, 3);
        tbl[8].s.ftype = 3'd1;
        tbl[8].e = mkExp(3'd1, 16'h0123, 16'hFFFF, 16'h0002, 16'h0003, 3);
        tbl[9].s.ftype = 3'd6; tbl[9].s.myID = 16'h00AA;
        tbl[9].e = tbl[8].e;
        for (int i = 0; i < 10; i++) run($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);

        // reset in the middle of a long scan
        for (int i = 0; i < 64; i++) nt[i] = 16'($urandom_range(1, 8));
        s = base; s.ftype = 3'd4; s.haveData = 1'b1; s.hop = 16'h0099; s.count = 5'd20;
        drive(s);
        ifc.en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.en = 1'b0;
        repeat (3) @(negedge clk);
        chk("midscan_index", {26'd0, ifc.nTableIndex_reward}, 32'd2);
        #2 nrst = 1'b1;
        #1;
        chkOut("midscan_reset", resetExp);
        chk("midscan_reset_index", {26'd0, ifc.nTableIndex_reward}, 32'd0);
        chk("midscan_reset_done", {31'd0, ifc.reward_done}, 32'd0);
        @(negedge clk);
        nrst = 1'b0;
        doneSeen = 0;
        repeat (30) begin
            @(negedge clk);
            if (ifc.reward_done === 1'b1) doneSeen++;
        end
        chk("midscan_no_done", doneSeen, 0);
        run("after_reset", tbl[0].s, model(tbl[0].s, resetExp));
        prev = model(tbl[0].s, resetExp);

        // randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 64; i++) nt[i] = 16'($urandom_range(1, 8));
            s.ftype    = 3'($urandom_range(0, 7));
            s.role     = 1'($urandom);
            s.amDest   = 1'($urandom);
            s.haveData = 1'($urandom);
            s.lowE     = 1'($urandom);
            s.myID     = 16'($urandom);
            s.energy   = 16'($urandom);
            s.hops     = 16'($urandom_range(0, 15));
            s.myQ      = 16'($urandom);
            s.fSrc     = 16'($urandom);
            s.cch      = 16'($urandom);
            s.hcch     = 16'($urandom_range(0, 7));
            s.hop      = 16'($urandom_range(1, 12));
            s.count    = 5'($urandom_range(0, 31));
            e = model(s, prev);
            run($sformatf("rnd%0d", n), s, e);
            prev = e;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
`default_nettype wire
